// File: rtl/sti_rcv.sv
`default_nettype none
// ============================================================================
// Module      : sti_rcv
// Description : Serial-to-parallel frame receiver. Collects an 8/16/24/32-bit
//               serial frame (MSB- or LSB-first) qualified by si_valid. When
//               si_valid drops, it extracts a 16-bit word and flags errors:
//               non-zero fill bits, overrun, or a short frame.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-low reset
//               cfg_load   - strobe latching cfg_* (accepted outside RECV only)
//               cfg_length - 00=8, 01=16, 10=24, 11=32 bit frames
//               cfg_fill   - 24/32-bit frames: 0=payload low, 1=payload high
//               cfg_msb    - 1=MSB first, 0=LSB first
//               cfg_low    - 8-bit frames: 1=byte in low half, 0=high half
//               si_data    - serial data bit
//               si_valid   - high for every bit of a frame
//               po_data    - recovered word, held between strobes
//               po_valid   - one-cycle strobe qualifying po_data/po_err
//               po_err     - frame error flag
//               frame_cnt  - completed frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module sti_rcv (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        si_data,
  input  logic        si_valid,
  output logic [15:0] po_data,
  output logic        po_valid,
  output logic        po_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_len;
  logic        r_fill;
  logic        r_msb;
  logic        r_low;
  logic [5:0]  r_cnt;
  logic [31:0] r_sr;
  logic        r_ovr;

  // A cfg_load arriving on the same edge as the first bit of a frame must
  // govern that bit's placement too, so use the incoming config there.
  logic        w_cfg_take;
  logic [1:0]  w_len;
  logic        w_msb;
  logic [2:0]  w_len_p1;
  logic [5:0]  w_n;
  logic [5:0]  w_k;
  logic [5:0]  w_pos6;
  logic [4:0]  w_pos;
  logic [31:0] w_sr_start;
  logic        w_short;
  logic        w_fill_bad;
  logic [15:0] w_data;
  logic        w_err;

  assign w_cfg_take = cfg_load && (r_state != S_RECV);
  assign w_len      = w_cfg_take ? cfg_length : r_len;
  assign w_msb      = w_cfg_take ? cfg_msb    : r_msb;
  assign w_len_p1   = {1'b0, w_len} + 3'd1;
  assign w_n        = {w_len_p1, 3'b000};
  // Bit index within the frame: 0 for the first bit, else the running count.
  assign w_k        = (r_state == S_RECV) ? r_cnt : 6'd0;
  assign w_pos6     = w_msb ? (w_n - 6'd1 - w_k) : w_k;
  assign w_pos      = w_pos6[4:0];
  assign w_sr_start = {31'd0, si_data} << w_pos;

  // Word extraction; only evaluated while in RECV, where cfg is stable.
  always_comb begin
    w_data     = 16'h0000;
    w_fill_bad = 1'b0;
    case (r_len)
      2'b00: w_data = r_low ? {8'h00, r_sr[7:0]} : {r_sr[7:0], 8'h00};
      2'b01: w_data = r_sr[15:0];
      2'b10: begin
        if (r_fill) begin
          w_data     = r_sr[23:8];
          w_fill_bad = |r_sr[7:0];
        end else begin
          w_data     = r_sr[15:0];
          w_fill_bad = |r_sr[23:16];
        end
      end
      default: begin
        if (r_fill) begin
          w_data     = r_sr[31:16];
          w_fill_bad = |r_sr[15:0];
        end else begin
          w_data     = r_sr[15:0];
          w_fill_bad = |r_sr[31:16];
        end
      end
    endcase
    w_short = (r_cnt < w_n);
    if (w_short) begin
      w_data = 16'h0000;
    end
    w_err = w_short | r_ovr | w_fill_bad;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_len     <= 2'b00;
      r_fill    <= 1'b0;
      r_msb     <= 1'b0;
      r_low     <= 1'b0;
      r_cnt     <= 6'd0;
      r_sr      <= 32'd0;
      r_ovr     <= 1'b0;
      po_data   <= 16'h0000;
      po_valid  <= 1'b0;
      po_err    <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      po_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (cfg_load) begin
            r_len  <= cfg_length;
            r_fill <= cfg_fill;
            r_msb  <= cfg_msb;
            r_low  <= cfg_low;
          end
          if (si_valid) begin
            r_sr    <= w_sr_start;
            r_cnt   <= 6'd1;
            r_ovr   <= 1'b0;
            r_state <= S_RECV;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RECV: begin
          if (si_valid) begin
            // Bits beyond the frame length are dropped but remembered.
            if (r_cnt == w_n) begin
              r_ovr <= 1'b1;
            end else begin
              r_sr[w_pos] <= si_data;
              r_cnt       <= r_cnt + 6'd1;
            end
          end else begin
            po_data   <= w_data;
            po_err    <= w_err;
            po_valid  <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sti_rcv.sv
`default_nettype none
// ============================================================================
// Module      : tb_sti_rcv
// Description : Directed self-checking bench for sti_rcv. Frames are driven
//               on the falling edge; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sti_rcv;

  logic        clk;
  logic        reset;
  logic        cfg_load;
  logic [1:0]  cfg_length;
  logic        cfg_fill;
  logic        cfg_msb;
  logic        cfg_low;
  logic        si_data;
  logic        si_valid;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_err;
  logic [7:0]  frame_cnt;

  int n_checks;
  int n_errors;
  int exp_cnt;

  logic [15:0] mon_data[$];
  logic        mon_err[$];

  sti_rcv u_dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_length (cfg_length),
    .cfg_fill   (cfg_fill),
    .cfg_msb    (cfg_msb),
    .cfg_low    (cfg_low),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .po_data    (po_data),
    .po_valid   (po_valid),
    .po_err     (po_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe so overlapping frames can be checked afterwards.
  always @(negedge clk) begin
    if (po_valid === 1'b1) begin
      mon_data.push_back(po_data);
      mon_err.push_back(po_err);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] len, input logic fill, input logic msb, input logic low);
    @(negedge clk);
    cfg_length = len;
    cfg_fill   = fill;
    cfg_msb    = msb;
    cfg_low    = low;
    cfg_load   = 1'b1;
    @(negedge clk);
    cfg_load   = 1'b0;
  endtask

  // Drives n bits of val taken as a w-bit frame; optionally fires a bogus
  // cfg_load on the fifth bit.
  task automatic send_bits(input logic [31:0] val, input int w, input int n,
                           input logic msb, input logic mid_load);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      si_valid = 1'b1;
      si_data  = msb ? val[w-1-k] : val[k];
      if (mid_load && k == 4) begin
        cfg_length = 2'b00;
        cfg_msb    = ~msb;
        cfg_fill   = 1'b1;
        cfg_load   = 1'b1;
      end else begin
        cfg_load   = 1'b0;
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  // Called right after end_frame: po_valid is due on the very next edge.
  task automatic expect_frame(input string tag, input logic [15:0] exp_data, input logic exp_err);
    @(negedge clk);
    exp_cnt++;
    chk({tag, "_valid"}, 32'(po_valid), 32'd1);
    chk({tag, "_data"}, 32'(po_data), 32'(exp_data));
    chk({tag, "_err"}, 32'(po_err), 32'(exp_err));
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt[7:0]));
    @(negedge clk);
    chk({tag, "_vlow"}, 32'(po_valid), 32'd0);
    chk({tag, "_hold"}, 32'(po_data), 32'(exp_data));
  endtask

  initial begin
    int base;
    n_checks   = 0;
    n_errors   = 0;
    exp_cnt    = 0;
    reset      = 1'b0;
    cfg_load   = 1'b0;
    cfg_length = 2'b00;
    cfg_fill   = 1'b0;
    cfg_msb    = 1'b0;
    cfg_low    = 1'b0;
    si_data    = 1'b0;
    si_valid   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(po_data),   32'h0);
    chk("rst_valid", 32'(po_valid),  32'h0);
    chk("rst_err",   32'(po_err),    32'h0);
    chk("rst_cnt",   32'(frame_cnt), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // 8-bit MSB-first, byte in low / high half
    cfg(2'b00, 1'b0, 1'b1, 1'b1);
    send_bits(32'hA5, 8, 8, 1'b1, 1'b0);
    end_frame();
    expect_frame("b8_low", 16'h00A5, 1'b0);
    cfg(2'b00, 1'b0, 1'b1, 1'b0);
    send_bits(32'hA5, 8, 8, 1'b1, 1'b0);
    end_frame();
    expect_frame("b8_high", 16'hA500, 1'b0);

    // 16-bit LSB-first
    cfg(2'b01, 1'b0, 1'b0, 1'b0);
    send_bits(32'h1234, 16, 16, 1'b0, 1'b0);
    end_frame();
    expect_frame("b16_lsb", 16'h1234, 1'b0);

    // 24-bit payload high, then a non-zero fill bit
    cfg(2'b10, 1'b1, 1'b1, 1'b0);
    send_bits(32'h123400, 24, 24, 1'b1, 1'b0);
    end_frame();
    expect_frame("b24_f1", 16'h1234, 1'b0);
    send_bits(32'h123401, 24, 24, 1'b1, 1'b0);
    end_frame();
    expect_frame("b24_fbad", 16'h1234, 1'b1);

    // 24-bit payload low, LSB-first
    cfg(2'b10, 1'b0, 1'b0, 1'b0);
    send_bits(32'h00ABCD, 24, 24, 1'b0, 1'b0);
    end_frame();
    expect_frame("b24_f0", 16'hABCD, 1'b0);

    // 32-bit: short frame of 20 bits, then a full payload-high frame
    cfg(2'b11, 1'b1, 1'b1, 1'b0);
    send_bits(32'hFFFFFFFF, 32, 20, 1'b1, 1'b0);
    end_frame();
    expect_frame("b32_short", 16'h0000, 1'b1);
    send_bits(32'h56780000, 32, 32, 1'b1, 1'b0);
    end_frame();
    expect_frame("b32_f1", 16'h5678, 1'b0);

    // 8-bit overrun: 10 bits 1111_0000_11
    cfg(2'b00, 1'b0, 1'b1, 1'b1);
    send_bits(32'h3C3, 10, 10, 1'b1, 1'b0);
    end_frame();
    expect_frame("b8_ovr", 16'h00F0, 1'b1);

    // cfg_load in the middle of a 16-bit frame must be ignored
    cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send_bits(32'hBEEF, 16, 16, 1'b1, 1'b1);
    end_frame();
    expect_frame("mid_cfg", 16'hBEEF, 1'b0);

    // Reset after 5 bits: no strobe, everything cleared to defaults
    base = mon_data.size();
    send_bits(32'hBEEF, 16, 5, 1'b1, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    si_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("prst_valid", 32'(po_valid),  32'h0);
    chk("prst_data",  32'(po_data),   32'h0);
    chk("prst_err",   32'(po_err),    32'h0);
    chk("prst_cnt",   32'(frame_cnt), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("prst_nopulse", 32'(mon_data.size()), 32'(base));
    exp_cnt = 0;
    // Default config after reset: 8-bit, LSB-first, byte high
    send_bits(32'h3C, 8, 8, 1'b0, 1'b0);
    end_frame();
    expect_frame("post_rst", 16'h3C00, 1'b0);

    // Back-to-back 16-bit frames with one idle cycle between them
    cfg(2'b01, 1'b0, 1'b0, 1'b0);
    base = mon_data.size();
    send_bits(32'hCAFE, 16, 16, 1'b0, 1'b0);
    end_frame();
    send_bits(32'h0F1E, 16, 16, 1'b0, 1'b0);
    end_frame();
    repeat (4) @(negedge clk);
    exp_cnt += 2;
    chk("b2b_pulses", 32'(mon_data.size()), 32'(base + 2));
    if (mon_data.size() >= base + 2) begin
      chk("b2b_d0", 32'(mon_data[base]),     32'hCAFE);
      chk("b2b_d1", 32'(mon_data[base + 1]), 32'h0F1E);
      chk("b2b_e0", 32'(mon_err[base]),      32'h0);
      chk("b2b_e1", 32'(mon_err[base + 1]),  32'h0);
    end
    chk("b2b_cnt", 32'(frame_cnt), 32'(exp_cnt[7:0]));

    // Run frame_cnt up to 255, then wrap it with one more frame
    cfg(2'b00, 1'b0, 1'b0, 1'b1);
    base = 255 - exp_cnt;
    for (int i = 0; i < base; i++) begin
      send_bits(32'h5A, 8, 8, 1'b0, 1'b0);
      end_frame();
    end
    repeat (4) @(negedge clk);
    exp_cnt = 255;
    chk("cnt_255", 32'(frame_cnt), 32'd255);
    send_bits(32'h5A, 8, 8, 1'b0, 1'b0);
    end_frame();
    expect_frame("wrap", 16'h005A, 1'b0);
    chk("cnt_wrap0", 32'(frame_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
